// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one signed fixed-point multiplier between N_REQ requesters.
// Optional clamping on overflow (with sat_flag output) is enabled by defining FP_ARB_SAT_EN.
module fp_mult_arbiter #(
  parameter int FP_WIDTH = 16,
  parameter int FP_FRAC  = 8,
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*FP_WIDTH-1:0] req_a,
  input  logic [N_REQ*FP_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [FP_WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
`ifdef FP_ARB_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [ID_W-1:0]              rr_ptr_q;
  logic signed [FP_WIDTH-1:0]   a_q, b_q;
  logic [ID_W-1:0]              id_q;
  logic                         rsp_valid_q;
  logic [FP_WIDTH-1:0]          rsp_data_q;
  logic [ID_W-1:0]              rsp_id_q;

  logic                         win_found_s;
  logic [ID_W-1:0]              win_idx_s;
  logic [ID_W:0]                cand_s;
  logic [ID_W-1:0]              rr_next_s;
  logic [FP_WIDTH-1:0]          sel_a_s, sel_b_s;
  logic signed [2*FP_WIDTH-1:0] prod_s;
  logic [FP_WIDTH-1:0]          res_s;

`ifdef FP_ARB_SAT_EN
  logic sat_q;
  logic res_sat_s;

  // Returns {overflow, result}; overflow when the bits above the kept window are not a pure sign extension.
  function automatic logic [FP_WIDTH:0] sat_trunc(input logic signed [2*FP_WIDTH-1:0] p);
    logic [FP_WIDTH-FP_FRAC:0] hi;
    logic [FP_WIDTH-1:0]       lo;
    hi = p[2*FP_WIDTH-1:FP_WIDTH-1+FP_FRAC];
    lo = FP_WIDTH'(p >>> FP_FRAC);
    if ((&hi) || !(|hi)) begin
      sat_trunc = {1'b0, lo};
    end else if (p[2*FP_WIDTH-1]) begin
      sat_trunc = {1'b1, 1'b1, {(FP_WIDTH-1){1'b0}}};
    end else begin
      sat_trunc = {1'b1, 1'b0, {(FP_WIDTH-1){1'b1}}};
    end
  endfunction

  assign {res_sat_s, res_s} = sat_trunc(prod_s);
  assign sat_flag = sat_q;
`else
  assign res_s = FP_WIDTH'(prod_s >>> FP_FRAC);
`endif

  assign prod_s    = a_q * b_q;
  assign sel_a_s   = req_a[win_idx_s*FP_WIDTH +: FP_WIDTH];
  assign sel_b_s   = req_b[win_idx_s*FP_WIDTH +: FP_WIDTH];
  assign rr_next_s = (win_idx_s == ID_W'(N_REQ-1)) ? '0 : win_idx_s + 1'b1;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping at N_REQ-1.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(N_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req_valid[cand_s[ID_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[ID_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic and the combinational grant, which is only ever given in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s && rst_n) begin
          state_d              = ST_OP;
          req_ready[win_idx_s] = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OP:   state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand capture and held response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
`ifdef FP_ARB_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && win_found_s) begin
        a_q      <= sel_a_s;
        b_q      <= sel_b_s;
        id_q     <= win_idx_s;
        rr_ptr_q <= rr_next_s;
      end
      if (state_q == ST_OP) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= res_s;
        rsp_id_q    <= id_q;
`ifdef FP_ARB_SAT_EN
        sat_q       <= res_sat_s;
`endif
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter: directed cases plus random traffic against a cycle-level reference model.
// Works with or without FP_ARB_SAT_EN defined.
module tb_fp_mult_arbiter;
  localparam int W = 16;
  localparam int F = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;
`ifdef FP_ARB_SAT_EN
  logic           sat_flag;
`endif

  fp_mult_arbiter #(.FP_WIDTH(W), .FP_FRAC(F), .N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef FP_ARB_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: 0 = waiting for a request, 1 = multiplying, 2 = holding a response
  int           m_phase = 0;
  int           m_rr    = 0;
  int           m_w     = 0;
  logic [W-1:0] m_a     = '0;
  logic [W-1:0] m_b     = '0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_id    = 0;
  logic         m_sat   = 1'b0;
  int           grants[$];
  int           grant_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, output logic s);
    longint      p;
    longint      q;
    logic [63:0] qv;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p >>> F;
    s = 1'b0;
`ifdef FP_ARB_SAT_EN
    if (q > 64'sd32767) begin
      s = 1'b1;
      q = 64'sd32767;
    end else if (q < -64'sd32768) begin
      s = 1'b1;
      q = -64'sd32768;
    end
`endif
    qv = q;
    return qv[W-1:0];
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_sat = 1'b0;
  endtask

  // Check all outputs against the model for the current cycle, then advance one clock.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           w;
    logic         s;
    #1;
    exp_rdy = '0;
    w = -1;
    if (m_phase == 0) w = pick(req_valid);
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_data", 32'(rsp_data), 32'(m_data));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
`ifdef FP_ARB_SAT_EN
    chk("sat_flag", 32'(sat_flag), 32'(m_sat));
`endif
    for (int k = 0; k < N; k++) begin
      if (req_ready[k]) begin
        grants.push_back(k);
        grant_cyc.push_back(cyc);
      end
    end
    if (m_phase == 0) begin
      if (w >= 0) begin
        m_a = req_a[w*W +: W];
        m_b = req_b[w*W +: W];
        m_w = w;
        m_rr = (w + 1) % N;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_data  = ref_mul(m_a, m_b, s);
      m_sat   = s;
      m_id    = m_w;
      m_valid = 1'b1;
      m_phase = 2;
    end else begin
      if (rsp_ready) begin
        m_valid = 1'b0;
        m_phase = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // One directed operation with the response held for hold+1 cycles under backpressure.
  task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_s, input int hold);
    logic [N-1:0] one;
    one = '0;
    one[idx] = 1'b1;
    req_valid = one;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    rsp_ready = 1'b0;
    #1;
    chk("op_grant", 32'(req_ready), 32'(one));
    step();
    req_valid = '0;
    step();
    req_valid = '1;
    for (int h = 0; h <= hold; h++) begin
      #1;
      chk("op_valid", 32'(rsp_valid), 32'd1);
      chk("op_data", 32'(rsp_data), 32'(exp_d));
      chk("op_id", 32'(rsp_id), 32'(idx));
      chk("op_no_grant", 32'(req_ready), 32'd0);
`ifdef FP_ARB_SAT_EN
      chk("op_sat", 32'(sat_flag), 32'(exp_s));
`endif
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
  endtask

  logic sat_exp_ovf;
  logic [W-1:0] ovf_exp;

  initial begin
    rst_n = 1'b0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // all requesters valid, consumer always ready
    req_valid = '1;
    rsp_ready = 1'b1;
    grants.delete();
    grant_cyc.delete();
    for (int i = 0; i < 15; i++) begin
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      step();
    end
    chk("rr_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(i % N));
      if (i > 0) chk("rr_spacing", (i < grant_cyc.size()) ? 32'(grant_cyc[i] - grant_cyc[i-1]) : 32'hFFFF_FFFF, 32'd3);
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) step();

    run_op(1, 16'h0180, 16'h0200, 16'h0300, 1'b0, 0);
    run_op(2, 16'hFF00, 16'h0080, 16'hFF80, 1'b0, 0);
    run_op(3, 16'h0100, 16'h0100, 16'h0100, 1'b0, 5);
`ifdef FP_ARB_SAT_EN
    ovf_exp = 16'h7FFF;
    sat_exp_ovf = 1'b1;
`else
    ovf_exp = 16'hFE00;
    sat_exp_ovf = 1'b0;
`endif
    run_op(0, 16'h7F00, 16'h0200, ovf_exp, sat_exp_ovf, 0);

    for (int i = 0; i < 300; i++) begin
      req_valid = N'($urandom_range(0, 15));
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      rsp_ready = 1'($urandom_range(0, 1));
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rsp_ready = 1'b0;

    // reset while a response is held; pointer must return to requester 0
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    req_valid = '1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    for (int i = 0; i < 3; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
